// File: rtl/sc_io_pkg.sv
// sc_io_pkg: shared constants and address decode for the sc_io_ports block.
//   GRP_*  : register group selected by addr[6:5]
//   CTL_*  : register index inside the control group (addr[4:2])
//   io_dec_t / io_decode : split a CPU byte address into select, group, index
package sc_io_pkg;

  localparam logic [1:0] GRP_OUT = 2'd0;
  localparam logic [1:0] GRP_IN  = 2'd1;
  localparam logic [1:0] GRP_TGL = 2'd2;
  localparam logic [1:0] GRP_CTL = 2'd3;

  localparam logic [2:0] CTL_STATUS = 3'd0;
  localparam logic [2:0] CTL_IRQEN  = 3'd1;
  localparam logic [2:0] CTL_CYCLE  = 3'd2;
  localparam logic [2:0] CTL_CYCCLR = 3'd3;

  typedef struct packed {
    logic       sel;
    logic [1:0] grp;
    logic [2:0] idx;
  } io_dec_t;

  // addr[1:0] (byte lane) and the bits above the select bit carry no meaning here.
  function automatic io_dec_t io_decode(input logic [31:0] addr, input logic [4:0] sel_bit);
    io_dec_t d;
    d.sel = addr[sel_bit];
    d.grp = addr[6:5];
    d.idx = addr[4:2];
    return d;
  endfunction

endpackage

// File: rtl/sc_io_ports_if.sv
// sc_io_ports_if: CPU-side data bus into the I/O block.
//   addr         : CPU byte address
//   datain       : CPU store data
//   we           : store enable
//   io_read_data : combinational readback towards the mem/io dataout mux
// Handshake: there is no valid/ready pair. A store is a single-cycle strobe;
// it commits at the rising clock edge while we=1 and the address selects I/O
// space. The block never stalls, so the CPU never waits. Reads have no strobe:
// io_read_data follows addr combinationally.
interface sc_io_ports_if #(
  parameter int DW = 32
);
  logic [31:0]   addr;
  logic [DW-1:0] datain;
  logic          we;
  logic [DW-1:0] io_read_data;

  modport master (output addr, output datain, output we, input io_read_data);
  modport slave  (input addr, input datain, input we, output io_read_data);
endinterface

// File: rtl/sc_io_in_sync.sv
// sc_io_in_sync: three-stage synchroniser for one input port plus change detect.
//   clock, clrn : clock and asynchronous active-high reset
//   d_i         : raw asynchronous input port
//   s2_o        : second sync stage, the value software reads
//   chg_o       : 1 for one cycle whenever s2 differs from the stage after it
module sc_io_in_sync #(
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          clrn,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] s2_o,
  output logic          chg_o
);

  logic [DW-1:0] s1_q, s2_q, s3_q;

  always_ff @(posedge clock or posedge clrn) begin
    if (clrn) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign s2_o  = s2_q;
  // s3 exists only to detect edges on the already-synchronised s2 value.
  assign chg_o = (s2_q != s3_q);

endmodule

// File: rtl/sc_io_ports.sv
// sc_io_ports: memory-mapped I/O block for the single-cycle CPU data path.
//   clock, clrn : clock and asynchronous active-high reset
//   bus         : CPU address / store data / store enable / readback
//   in_ports    : N_IN flattened input ports, port i = [i*DW +: DW]
//   out_ports   : N_OUT flattened registered output ports
//   irq         : |(STATUS & IRQ_EN)
// Register map (addr[IO_SEL_BIT]=1, grp=addr[6:5], idx=addr[4:2]):
//   grp0 OUT[idx] r/w, grp1 IN[idx] r/o, grp2 OUT[idx] xor-toggle on write,
//   grp3 idx0 STATUS (W1C), idx1 IRQ_EN, idx2 CYCLE r/o, idx3 CYCLE clear.
//   Anything else reads 0 and ignores writes.
module sc_io_ports
  import sc_io_pkg::*;
#(
  parameter int DW         = 32,
  parameter int N_OUT      = 2,
  parameter int N_IN       = 2,
  parameter int IO_SEL_BIT = 7
) (
  input  logic                clock,
  input  logic                clrn,
  sc_io_ports_if.slave        bus,
  input  logic [N_IN*DW-1:0]  in_ports,
  output logic [N_OUT*DW-1:0] out_ports,
  output logic                irq
);

  io_dec_t dec;
  logic    wr;
  logic    ctl_wr;

  assign dec    = io_decode(bus.addr, 5'(IO_SEL_BIT));
  assign wr     = bus.we & dec.sel;
  assign ctl_wr = wr && (dec.grp == GRP_CTL);

  // ---------------------------------------------------------------- inputs
  logic [DW-1:0]   in_s2 [N_IN];
  logic [N_IN-1:0] chg;

  for (genvar g = 0; g < N_IN; g++) begin : g_in
    sc_io_in_sync #(.DW(DW)) u_sync (
      .clock (clock),
      .clrn  (clrn),
      .d_i   (in_ports[g*DW +: DW]),
      .s2_o  (in_s2[g]),
      .chg_o (chg[g])
    );
  end

  // ---------------------------------------------------------------- outputs
  logic [DW-1:0] out_q [N_OUT];
  logic [DW-1:0] out_d [N_OUT];

  // Out-of-range idx never matches any i, so those writes fall through.
  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      out_d[i] = out_q[i];
      if (wr && (dec.idx == 3'(i))) begin
        if (dec.grp == GRP_OUT) begin
          out_d[i] = bus.datain;
        end else if (dec.grp == GRP_TGL) begin
          out_d[i] = out_q[i] ^ bus.datain;
        end
      end
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign out_ports[g*DW +: DW] = out_q[g];
  end

  // ---------------------------------------------------------------- control
  logic [N_IN-1:0] status_q, status_d, status_clr;
  logic [N_IN-1:0] irq_en_q, irq_en_d;
  logic [DW-1:0]   cycle_q, cycle_d;

  always_comb begin
    status_clr = '0;
    irq_en_d   = irq_en_q;
    cycle_d    = cycle_q + DW'(1);
    if (ctl_wr) begin
      case (dec.idx)
        CTL_STATUS: status_clr = bus.datain[N_IN-1:0];
        CTL_IRQEN:  irq_en_d   = bus.datain[N_IN-1:0];
        CTL_CYCCLR: cycle_d    = '0;
        default:    ;
      endcase
    end
    // A change arriving in the clearing cycle must not be lost, so set wins.
    status_d = (status_q & ~status_clr) | chg;
  end

  always_ff @(posedge clock or posedge clrn) begin
    if (clrn) begin
      for (int i = 0; i < N_OUT; i++) begin
        out_q[i] <= '0;
      end
      status_q <= '0;
      irq_en_q <= '0;
      cycle_q  <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        out_q[i] <= out_d[i];
      end
      status_q <= status_d;
      irq_en_q <= irq_en_d;
      cycle_q  <= cycle_d;
    end
  end

  assign irq = |(status_q & irq_en_q);

  // ---------------------------------------------------------------- readback
  logic [DW-1:0] rdata;

  always_comb begin
    rdata = '0;
    if (dec.sel) begin
      case (dec.grp)
        GRP_OUT, GRP_TGL: begin
          for (int i = 0; i < N_OUT; i++) begin
            if (dec.idx == 3'(i)) rdata = out_q[i];
          end
        end
        GRP_IN: begin
          for (int i = 0; i < N_IN; i++) begin
            if (dec.idx == 3'(i)) rdata = in_s2[i];
          end
        end
        default: begin
          case (dec.idx)
            CTL_STATUS: rdata[N_IN-1:0] = status_q;
            CTL_IRQEN:  rdata[N_IN-1:0] = irq_en_q;
            CTL_CYCLE:  rdata           = cycle_q;
            default:    ;
          endcase
        end
      endcase
    end
  end

  assign bus.io_read_data = rdata;

endmodule
